// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter and access sequencer for the data memory.
// Each access takes IDLE -> ACCESS -> DONE; out-of-range addresses never raise Ewr/Erd.
module dmem_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              Req0,
    input  logic              We0,
    input  logic [ADDR_W-1:0] Addr0,
    input  logic [DATA_W-1:0] WData0,
    output logic              Ack0,
    output logic [DATA_W-1:0] RData0,
    output logic              Err0,
    input  logic              Req1,
    input  logic              We1,
    input  logic [ADDR_W-1:0] Addr1,
    input  logic [DATA_W-1:0] WData1,
    output logic              Ack1,
    output logic [DATA_W-1:0] RData1,
    output logic              Err1,
    output logic              Ewr,
    output logic              Erd,
    output logic [ADDR_W-1:0] Addr,
    output logic [DATA_W-1:0] RDir,
    input  logic [DATA_W-1:0] MOut
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

    state_t            state_reg, state_next;
    logic              gnt_reg, gnt_next;
    logic              grant;
    logic              we_reg;
    logic              in_rng_reg;
    logic              rr_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [DATA_W-1:0] rdir_reg;

    logic [1:0]        req;
    logic [1:0]        we_in;
    logic [ADDR_W-1:0] addr_in  [2];
    logic [DATA_W-1:0] wdata_in [2];
    logic [1:0]        ack;

    assign req         = {Req1, Req0};
    assign we_in       = {We1, We0};
    assign addr_in[0]  = Addr0;
    assign addr_in[1]  = Addr1;
    assign wdata_in[0] = WData0;
    assign wdata_in[1] = WData1;

    always_comb begin
        state_next = state_reg;
        gnt_next   = gnt_reg;
        grant      = 1'b0;
        case (state_reg)
            IDLE: begin
                if (req != 2'b00) begin
                    grant      = 1'b1;
                    // rr_reg names the port that wins a tie
                    gnt_next   = (req == 2'b11) ? rr_reg : req[1];
                    state_next = ACCESS;
                end
            end
            ACCESS:  state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            gnt_reg    <= 1'b0;
            we_reg     <= 1'b0;
            in_rng_reg <= 1'b0;
            rr_reg     <= 1'b0;
            addr_reg   <= '0;
            rdir_reg   <= '0;
        end else begin
            state_reg <= state_next;
            if (grant) begin
                gnt_reg    <= gnt_next;
                we_reg     <= we_in[gnt_next];
                addr_reg   <= addr_in[gnt_next];
                rdir_reg   <= wdata_in[gnt_next];
                in_rng_reg <= (addr_in[gnt_next] < DEPTH_A);
            end
            if (state_reg == DONE) begin
                rr_reg <= ~gnt_reg;
            end
        end
    end

    // Gated by rst_n so a reset cycle can never touch memory
    assign Ewr  = rst_n & (state_reg == ACCESS) & we_reg & in_rng_reg;
    assign Erd  = rst_n & (state_reg == ACCESS) & ~we_reg & in_rng_reg;
    assign Addr = addr_reg;
    assign RDir = rdir_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : gen_port
            localparam logic PORT_ID = 1'(gi);
            logic [DATA_W-1:0] rdata_reg;
            logic              err_reg;

            // Results land on the ACCESS edge so they are valid alongside Ack in DONE
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    rdata_reg <= '0;
                    err_reg   <= 1'b0;
                end else if ((state_reg == ACCESS) && (gnt_reg == PORT_ID)) begin
                    err_reg <= ~in_rng_reg;
                    if (!we_reg) begin
                        rdata_reg <= in_rng_reg ? MOut : '0;
                    end
                end
            end

            assign ack[gi] = rst_n & (state_reg == DONE) & (gnt_reg == PORT_ID);
        end
    endgenerate

    assign Ack0   = ack[0];
    assign Ack1   = ack[1];
    assign RData0 = gen_port[0].rdata_reg;
    assign RData1 = gen_port[1].rdata_reg;
    assign Err0   = gen_port[0].err_reg;
    assign Err1   = gen_port[1].err_reg;

endmodule
